// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS sequencer and its datapath.
// The master side is the controller, which reads instruction fields and status and drives every select and enable.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memreq;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       instret;
    logic       illegal;
    logic       memerr;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, memready,
        output memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, pcsrc, pcen, instret, illegal,
               memerr, state
    );

    modport slave (
        output op, funct, zero, memready,
        input  memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, pcsrc, pcen, instret, illegal,
               memerr, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore sequencer for the multicycle MIPS datapath.
// It decodes op/funct, stalls on memready, and flags illegal instructions and memory-wait timeouts.
module mc_controller #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEXE = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // A zero limit still needs a one-bit counter so the declarations stay legal.
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_waitCnt;
    logic            w_memState;
    logic            w_timeout;
    logic            w_legalFunct;
    logic [2:0]      w_functAlu;

    logic            w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg;
    logic            w_regwrite, w_alusrca, w_pcen, w_instret, w_illegal, w_memerr;
    logic [1:0]      w_alusrcb, w_pcsrc;
    logic [2:0]      w_alucontrol;

    assign w_memState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_timeout  = (WAIT_LIMIT > 0) && w_memState && !bus.memready &&
                        (r_waitCnt == CW'(WAIT_LIMIT));

    always_comb begin
        w_legalFunct = 1'b1;
        w_functAlu   = ALU_ADD;
        case (bus.funct)
            6'b100000: w_functAlu = ALU_ADD;
            6'b100010: w_functAlu = ALU_SUB;
            6'b100100: w_functAlu = ALU_AND;
            6'b100101: w_functAlu = ALU_OR;
            6'b101010: w_functAlu = ALU_SLT;
            default:   w_legalFunct = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Any stall that ends (state change, ready, or timeout) restarts the wait count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= '0;
        end else if ((w_nextState != r_state) || bus.memready || w_timeout) begin
            r_waitCnt <= '0;
        end else if (w_memState && (WAIT_LIMIT > 0)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_alucontrol = 3'b000;
        w_pcsrc      = 2'b00;
        w_pcen       = 1'b0;
        w_instret    = 1'b0;
        w_illegal    = 1'b0;
        w_memerr     = 1'b0;

        case (r_state)
            FETCH: begin
                w_alusrcb    = 2'b01;
                w_alucontrol = ALU_ADD;
                if (bus.memready) begin
                    w_irwrite   = 1'b1;
                    w_pcen      = 1'b1;
                    w_nextState = DECODE;
                end
            end
            DECODE: begin
                w_alusrcb    = 2'b11;
                w_alucontrol = ALU_ADD;
                if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
                    w_nextState = MEMADR;
                end else if ((bus.op == OP_RTYPE) && w_legalFunct) begin
                    w_nextState = EXECUTE;
                end else if (bus.op == OP_BEQ) begin
                    w_nextState = BRANCH;
                end else if (bus.op == OP_ADDI) begin
                    w_nextState = ADDIEXE;
                end else if (bus.op == OP_J) begin
                    w_nextState = JUMP;
                end else begin
                    w_illegal   = 1'b1;
                    w_nextState = FETCH;
                end
            end
            MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alucontrol = ALU_ADD;
                w_nextState  = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                w_iord = 1'b1;
                if (bus.memready) begin
                    w_nextState = MEMWB;
                end
            end
            MEMWB: begin
                w_memtoreg  = 1'b1;
                w_regwrite  = 1'b1;
                w_instret   = 1'b1;
                w_nextState = FETCH;
            end
            MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (bus.memready) begin
                    w_instret   = 1'b1;
                    w_nextState = FETCH;
                end
            end
            EXECUTE: begin
                w_alusrca    = 1'b1;
                w_alucontrol = w_functAlu;
                w_nextState  = ALUWB;
            end
            ALUWB: begin
                w_regdst    = 1'b1;
                w_regwrite  = 1'b1;
                w_instret   = 1'b1;
                w_nextState = FETCH;
            end
            BRANCH: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ALU_SUB;
                w_pcsrc      = 2'b01;
                w_pcen       = bus.zero;
                w_instret    = 1'b1;
                w_nextState  = FETCH;
            end
            ADDIEXE: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alucontrol = ALU_ADD;
                w_nextState  = ADDIWB;
            end
            ADDIWB: begin
                w_regwrite  = 1'b1;
                w_instret   = 1'b1;
                w_nextState = FETCH;
            end
            JUMP: begin
                w_pcsrc     = 2'b10;
                w_pcen      = 1'b1;
                w_instret   = 1'b1;
                w_nextState = FETCH;
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase

        // A timed-out access is abandoned: no side effects, restart at FETCH.
        if (w_timeout) begin
            w_memerr    = 1'b1;
            w_irwrite   = 1'b0;
            w_pcen      = 1'b0;
            w_memwrite  = 1'b0;
            w_instret   = 1'b0;
            w_nextState = FETCH;
        end

        if (reset) begin
            w_pcen     = 1'b0;
            w_irwrite  = 1'b0;
            w_regwrite = 1'b0;
            w_memwrite = 1'b0;
            w_instret  = 1'b0;
            w_illegal  = 1'b0;
            w_memerr   = 1'b0;
        end
    end

    assign bus.memreq     = w_memState;
    assign bus.iord       = w_iord;
    assign bus.memwrite   = w_memwrite;
    assign bus.irwrite    = w_irwrite;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regwrite   = w_regwrite;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.alucontrol = w_alucontrol;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.pcen       = w_pcen;
    assign bus.instret    = w_instret;
    assign bus.illegal    = w_illegal;
    assign bus.memerr     = w_memerr;
    assign bus.state      = r_state;
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the MIPS datapath: a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. The datapath shares one memory for instructions and data and reuses one ALU, so it needs this block to drive every mux select and write enable. The block decodes op/funct, generates all datapath control each cycle, stalls on a memory ready handshake, and flags illegal opcodes and memory timeouts.

## Interface
- WAIT_LIMIT, 15: maximum consecutive memready=0 cycles tolerated in a memory state; 0 disables the timeout.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- memready  input  1  memory completes the current access this cycle.
- memreq  output  1  memory access active (FETCH, MEMRD, MEMWR).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  output  1  memory write enable.
- irwrite  output  1  instruction register load.
- regdst  output  1  write register select: 0 = rt, 1 = rd.
- memtoreg  output  1  writeback select: 0 = ALUOut, 1 = data register.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- alucontrol  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC register load.
- instret  output  1  one-cycle pulse on the final cycle of a completed instruction.
- illegal  output  1  one-cycle pulse when DECODE sees an unsupported op or R-type funct.
- memerr  output  1  one-cycle pulse when a memory-wait timeout fires.
- state  output  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXE 9, ADDIWB 10, JUMP 11. Encodings 12–15 are unreachable and must transition to FETCH.
- Outputs are a function of state plus the inputs listed per state. Any output not listed for a state is 0.
  - FETCH: memreq=1, alusrcb=01, alucontrol=add. If memready=1, also irwrite=1 and pcen=1 (pcsrc=00).
  - DECODE: alusrcb=11, alucontrol=add.
  - MEMADR: alusrca=1, alusrcb=10, add.
  - MEMRD: memreq=1, iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: memreq=1, iord=1, memwrite=1. Memory commits the write on the memready=1 cycle only.
  - EXECUTE: alusrca=1. alucontrol decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, alucontrol=sub, pcsrc=01, pcen=zero.
  - ADDIEXE: alusrca=1, alusrcb=10, add.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcen=1.
- Transitions:
  - FETCH → DECODE on memready, else stay.
  - DECODE by op: 100011/101011 → MEMADR; 000000 with legal funct → EXECUTE; 000100 → BRANCH; 001000 → ADDIEXE; 000010 → JUMP; anything else → FETCH with illegal=1.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB on memready.
  - MEMWR → FETCH on memready.
  - EXECUTE → ALUWB; ADDIEXE → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- instret=1 in: MEMWB; ALUWB; ADDIWB; BRANCH; JUMP; MEMWR when memready=1.
- Wait counter:
  - Width clog2(WAIT_LIMIT+1).
  - Clears on every state change and whenever memready=1.
  - Increments each memreq=1 cycle with memready=0.
  - When the counter equals WAIT_LIMIT and memready=0 (WAIT_LIMIT>0): pulse memerr, suppress irwrite, pcen and memwrite that cycle, force next state FETCH (FETCH re-enters itself), clear the counter, and do not assert instret.

## Timing
- Reset is sampled on the rising edge. While reset=1, pcen, irwrite, regwrite and memwrite are forced 0, and instret, illegal and memerr are forced 0.
- The first edge with reset=1 loads state=FETCH and clears the wait counter. Reset mid-instruction abandons the instruction with no further writes.
- Cycles per instruction with memready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- illegal and memerr are combinational pulses valid in the DECODE cycle and the timeout cycle respectively.
- memready is ignored outside memory states.

## Test plan
- Reset, then lw with memready=1: states 0,1,2,3,4,0. Cycle 4 has regwrite=1, memtoreg=1, regdst=0, instret=1.
- sw with memready low for 3 cycles in MEMWR: memwrite stays 1 for 4 cycles, instret pulses only on the memready cycle, next state FETCH.
- beq with zero=1 then zero=0: pcen=1 with pcsrc=01 in the first case, pcen=0 in the second; both take 3 cycles.
- R-type funct 101010 gives alucontrol=111 in EXECUTE. funct 000000 gives illegal=1 in DECODE and returns to FETCH with no regwrite.
- WAIT_LIMIT=3 with memready held 0 in FETCH: memerr pulses on the 4th cycle, and irwrite/pcen stay 0 throughout.
- Reset asserted during ALUWB: regwrite=0 that cycle, state=FETCH next cycle.
